irq_ctrl: RTL and testbench

Memory-mapped interrupt controller that collects peripheral interrupt lines (timer `irq`, UART, GPIO, …) and drives the single external interrupt input of the core. It latches edge-type sources, passes level-type sources through, applies per-source enables, and resolves the winner by fixed index priority. A claim/complete protocol supports preemption-by-priority nesting. It sits on the same word-addressed peripheral bus as the timer, directly downstream of the timer's `irq` output.

---
 rtl/irq_ctrl.sv | 120 ++++++++++++
 tb/tb_irq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level sources, per-source enable, fixed index priority,
// claim/complete nesting. Define IRQC_SYNC_EN to add a 2-flop synchronizer on src.
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_write,
  input  logic             bus_read,
  input  logic [5:0]       addr_word,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] src,
  output logic             irq
);

  localparam logic [5:0] A_PENDING   = 6'h0;
  localparam logic [5:0] A_ENABLE    = 6'h1;
  localparam logic [5:0] A_EDGE      = 6'h2;
  localparam logic [5:0] A_CLAIM     = 6'h3;
  localparam logic [5:0] A_INSERVICE = 6'h4;
  localparam logic [5:0] A_RAW       = 6'h5;
  localparam logic [5:0] A_FORCE     = 6'h6;

  logic [N_SRC-1:0] src_s;

`ifdef IRQC_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  logic [N_SRC-1:0] src_prev_q, latch_q, latch_d, enable_q, edge_q, insvc_q, insvc_d;
  logic [N_SRC-1:0] pending, cand;
  logic [4:0]       best_idx, top_idx, cmpl_id;
  logic             cand_any, claim, complete, wr_pend, wr_force, irq_q, irq_d;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:N_SRC];

  assign wr_pend  = bus_write && (addr_word == A_PENDING);
  assign wr_force = bus_write && (addr_word == A_FORCE);
  assign complete = bus_write && (addr_word == A_CLAIM);
  assign cmpl_id  = wdata[4:0];
  assign cand     = pending & enable_q & ~insvc_q;
  assign cand_any = |cand;
  assign claim    = bus_read && (addr_word == A_CLAIM) && cand_any;

  // Per-source latch and in-service update; a set always beats a clear on the same edge.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      logic set_b, clr_b;
      assign pending[gi] = edge_q[gi] ? latch_q[gi] : src_s[gi];
      assign set_b = edge_q[gi] & ((src_s[gi] & ~src_prev_q[gi]) | (wr_force & wdata[gi]));
      assign clr_b = edge_q[gi] & ((claim & (best_idx == 5'(gi))) | (wr_pend & wdata[gi]));
      assign latch_d[gi] = set_b | (latch_q[gi] & ~clr_b);
      assign insvc_d[gi] = (claim & (best_idx == 5'(gi))) |
                           (insvc_q[gi] & ~(complete & (cmpl_id == 5'(gi + 1))));
    end
  endgenerate

  always_comb begin
    best_idx = '0;
    top_idx  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i])    best_idx = 5'(i);
      if (insvc_q[i]) top_idx  = 5'(i);
    end
  end

  assign irq_d = cand_any && ((insvc_q == '0) || (best_idx < top_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev_q <= '0;
      latch_q    <= '0;
      enable_q   <= '0;
      edge_q     <= '0;
      insvc_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      src_prev_q <= src_s;
      latch_q    <= latch_d;
      insvc_q    <= insvc_d;
      irq_q      <= irq_d;
      if (bus_write && (addr_word == A_ENABLE)) enable_q <= wdata[N_SRC-1:0];
      if (bus_write && (addr_word == A_EDGE))   edge_q   <= wdata[N_SRC-1:0];
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    if (bus_read) begin
      case (addr_word)
        A_PENDING:   rdata = 32'(pending);
        A_ENABLE:    rdata = 32'(enable_q);
        A_EDGE:      rdata = 32'(edge_q);
        A_CLAIM:     rdata = cand_any ? ({27'd0, best_idx} + 32'd1) : 32'd0;
        A_INSERVICE: rdata = 32'(insvc_q);
        A_RAW:       rdata = 32'(src_s);
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed stimulus, a bit-vector reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_irq_ctrl;

`ifdef IRQC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [5:0]  addr_word = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  src = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.N_SRC(8)) dut (
    .clk(clk), .rst(rst), .bus_write(bus_write), .bus_read(bus_read),
    .addr_word(addr_word), .wdata(wdata), .rdata(rdata), .src(src), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [7:0] m_latch = 0, m_en = 0, m_edge = 0, m_isv = 0, m_prev = 0, m_s1 = 0, m_s2 = 0;
  bit       m_irq = 0;

  function automatic bit [7:0] m_sampled();
`ifdef IRQC_SYNC_EN
    return m_s2;
`else
    return src;
`endif
  endfunction

  function automatic bit [7:0] m_pending();
    bit [7:0] s = m_sampled();
    bit [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_edge[i] ? m_latch[i] : s[i];
    return p;
  endfunction

  // Lowest set index, or -1 when the vector is empty
  function automatic int first_set(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int m_best();
    return first_set(m_pending() & m_en & ~m_isv);
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'h0: return {24'd0, m_pending()};
      6'h1: return {24'd0, m_en};
      6'h2: return {24'd0, m_edge};
      6'h3: return 32'(m_best() + 1);
      6'h4: return {24'd0, m_isv};
      6'h5: return {24'd0, m_sampled()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit [7:0] s;
    int       best, top;
    bit       nxt;
    s    = m_sampled();
    best = m_best();
    top  = first_set(m_isv);
    nxt  = (best >= 0) && (top < 0 || best < top);
    if (rst) begin
      m_latch = 0; m_en = 0; m_edge = 0; m_isv = 0; m_prev = 0; m_s1 = 0; m_s2 = 0; m_irq = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m_edge[i]) begin
          if (bus_read && addr_word == 6'h3 && best == i) m_latch[i] = 0;
          if (bus_write && addr_word == 6'h0 && wdata[i]) m_latch[i] = 0;
          if ((bus_write && addr_word == 6'h6 && wdata[i]) || (s[i] && !m_prev[i])) m_latch[i] = 1;
        end
      end
      if (bus_read && addr_word == 6'h3 && best >= 0) m_isv[best] = 1;
      if (bus_write && addr_word == 6'h3 && wdata[4:0] >= 1 && wdata[4:0] <= 8)
        m_isv[wdata[4:0] - 1] = 0;
      if (bus_write && addr_word == 6'h1) m_en = wdata[7:0];
      if (bus_write && addr_word == 6'h2) m_edge = wdata[7:0];
      m_prev = s;
      m_s2 = m_s1;
      m_s1 = src;
      m_irq = nxt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_rdata", rdata, bus_read ? m_read(addr_word) : 32'd0);
    chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    bus_write = 0;
    bus_read  = 0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus_write = 1; addr_word = a; wdata = d;
    $display("WR addr=%0h data=%h", a, d);
    cycle();
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
    bus_read = 1; addr_word = a;
    #2;
    $display("RD addr=%0h data=%h", a, rdata);
    chk(nm, rdata, exp);
    cycle();
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    chk(nm, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    int lat;
    wait_n(2);
    rst = 0;
    chk_irq("reset_irq", 0);
    rd(6'h0, 0, "reset_pending");
    rd(6'h1, 0, "reset_enable");

    // Edge latch, latency, claim and complete
    wr(6'h2, 32'h01);
    wr(6'h1, 32'h01);
    src[0] = 1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) src[0] = 0;
      if (irq && lat == 0) lat = k;
    end
    chk("irq_latency", lat, LAT);
    rd(6'h0, 32'h01, "edge_pending");
    rd(6'h3, 32'd1, "edge_claim");
    rd(6'h0, 32'h00, "edge_pending_cleared");
    chk_irq("edge_irq_dropped", 0);
    rd(6'h4, 32'h01, "edge_inservice");
    wr(6'h3, 32'd1);
    rd(6'h4, 32'h00, "edge_completed");

    // Level source
    wr(6'h2, 32'h00);
    wr(6'h1, 32'h04);
    src[2] = 1;
    wait_n(4);
    rd(6'h3, 32'd3, "level_claim");
    wait_n(2);
    chk_irq("level_irq_in_service", 0);
    wr(6'h3, 32'd3);
    wait_n(1);
    chk_irq("level_irq_reassert", 1);
    src[2] = 0;
    wait_n(4);

    // Priority / preemption
    wr(6'h2, 32'hFF);
    wr(6'h1, 32'hFF);
    src[4] = 1; cycle(); src[4] = 0;
    wait_n(4);
    rd(6'h3, 32'd5, "prio_claim5");
    wait_n(2);
    chk_irq("prio_irq_low", 0);
    src[1] = 1; cycle(); src[1] = 0;
    wait_n(4);
    chk_irq("prio_preempt_irq", 1);
    rd(6'h3, 32'd2, "prio_claim2");
    rd(6'h4, 32'h12, "prio_inservice");
    src[6] = 1; cycle(); src[6] = 0;
    wait_n(4);
    chk_irq("prio_no_preempt", 0);
    wr(6'h3, 32'd2);
    wait_n(2);
    chk_irq("prio_still_blocked", 0);
    wr(6'h3, 32'd5);
    wait_n(1);
    chk_irq("prio_after_complete", 1);
    rd(6'h3, 32'd7, "prio_claim7");
    wr(6'h3, 32'd7);

    // Masking, FORCE and W1C
    wr(6'h1, 32'h00);
    wr(6'h6, 32'h80);
    rd(6'h0, 32'h80, "force_pending");
    chk_irq("masked_irq", 0);
    wr(6'h1, 32'h80);
    wait_n(1);
    chk_irq("unmasked_irq", 1);
    wr(6'h0, 32'h80);
    wait_n(1);
    chk_irq("w1c_irq", 0);
    rd(6'h0, 32'h00, "w1c_pending");

    // Boundaries
    wr(6'h1, 32'h01);
    wr(6'h6, 32'h01);
    rd(6'h3, 32'd1, "bnd_claim1");
    wr(6'h3, 32'd0);
    wr(6'h3, 32'd9);
    rd(6'h4, 32'h01, "bnd_bad_complete");
    wr(6'h3, 32'd1);
    rd(6'h3, 32'd0, "bnd_empty_claim");
    rd(6'h4, 32'h00, "bnd_empty_claim_noeffect");
    wr(6'h6, 32'h01);
    src[0] = 1;
    rd(6'h3, 32'd1, "bnd_claim_with_edge");
    wait_n(3);
    rd(6'h0, 32'h01, "bnd_edge_resets_pending");
    src[0] = 0;
    wr(6'h3, 32'd1);
    wr(6'h0, 32'h01);

    // Reset mid-service
    wr(6'h1, 32'hFF);
    wr(6'h6, 32'h02);
    rd(6'h3, 32'd2, "rst_claim2");
    wr(6'h6, 32'h01);
    wait_n(1);
    chk_irq("rst_pre_irq", 1);
    rd(6'h4, 32'h02, "rst_pre_inservice");
    rst = 1;
    cycle();
    rst = 0;
    chk_irq("rst_irq", 0);
    rd(6'h0, 0, "rst_pending");
    rd(6'h1, 0, "rst_enable");
    rd(6'h2, 0, "rst_edge");
    rd(6'h4, 0, "rst_inservice");
    wait_n(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
